// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing fetch/decode/memory/ALU/branch
// steps, ALU-op decode, condition evaluation and the NZCV flags register.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] flags,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [1:0] alu_dec;
  logic       is_cmp;
  logic       cond_ex;
  logic       fN, fZ, fC, fV;

  assign {fN, fZ, fC, fV} = flags_q;
  assign is_cmp = (funct[4:1] == 4'b1010);

  always_comb begin
    case (funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: alu_dec = 2'b01;
      default: alu_dec = 2'b00;
    endcase
  end

  always_comb begin
    case (cond)
      4'b0000: cond_ex = fZ;
      4'b0001: cond_ex = ~fZ;
      4'b0010: cond_ex = fC;
      4'b0011: cond_ex = ~fC;
      4'b0100: cond_ex = fN;
      4'b0101: cond_ex = ~fN;
      4'b0110: cond_ex = fV;
      4'b0111: cond_ex = ~fV;
      4'b1000: cond_ex = fC & ~fZ;
      4'b1001: cond_ex = ~fC | fZ;
      4'b1010: cond_ex = (fN == fV);
      4'b1011: cond_ex = (fN != fV);
      4'b1100: cond_ex = ~fZ & (fN == fV);
      4'b1101: cond_ex = fZ | (fN != fV);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    flags_d    = flags_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex)          state_d = S_FETCH;
        else case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
        // S-suffixed ops and CMP latch the ALU's flags at the end of execute
        if (funct[0] || is_cmp) flags_d = ALUFlags;
      end
      S_ALUWB: begin
        ALUControl = alu_dec;
        RegWrite   = ~is_cmp;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign flags = flags_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: each driven cycle pushes
// its hand-computed expected state/controls/flags, a negedge monitor compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond;
  logic [3:0] ALUFlags;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl;
  logic [3:0] flags, state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .flags(flags), .state(state)
  );

  always #5 clk = ~clk;

  // ctl = {PCWrite,IRWrite,MemWrite,RegWrite, AdrSrc,ALUSrcA,ALUSrcB, ResultSrc,ALUControl}
  localparam logic [11:0] C_F1    = 12'b1100_0110_1000;
  localparam logic [11:0] C_F0    = 12'b0000_0110_1000;
  localparam logic [11:0] C_DEC   = 12'b0000_0110_1000;
  localparam logic [11:0] C_MADR  = 12'b0000_0001_0000;
  localparam logic [11:0] C_MRD   = 12'b0000_1000_0000;
  localparam logic [11:0] C_MWB   = 12'b0001_0000_0100;
  localparam logic [11:0] C_MWR   = 12'b0010_1000_0000;
  localparam logic [11:0] C_BR    = 12'b1000_0001_1000;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [11:0] ctl;
    logic [3:0] fl;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = sb.pop_front();
      act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s controls: got %b expected %b", e.nm, act, e.ctl);
      end
      checks++;
      if (flags !== e.fl) begin
        errors++;
        $display("FAIL %s flags: got %b expected %b", e.nm, flags, e.fl);
      end
    end
  end

  // Drive one cycle's inputs, queue the expected view of that cycle, advance.
  task automatic step(input string nm, input logic rst, input logic mr,
                      input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                      input logic [3:0] af, input logic [3:0] est,
                      input logic [11:0] ectl, input logic [3:0] efl);
    exp_t e;
    reset = rst; mem_ready = mr; op = o; funct = f; cond = c; ALUFlags = af;
    e.nm = nm; e.st = est; e.ctl = ectl; e.fl = efl;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'd0; cond = 4'b1110; ALUFlags = 4'b0000;
    @(posedge clk); #1;
    step("rst1", 1, 1, 2'b00, 6'b000000, 4'b1110, 4'b1111, 4'd0, C_F1, 4'b0000);
    step("rst2", 1, 1, 2'b00, 6'b000000, 4'b1110, 4'b1111, 4'd0, C_F1, 4'b0000);

    // ADDS register
    step("adds_f",  0, 1, 2'b00, 6'b001001, 4'b1110, 4'b0100, 4'd0, C_F1, 4'b0000);
    step("adds_d",  0, 0, 2'b00, 6'b001001, 4'b1110, 4'b0100, 4'd1, C_DEC, 4'b0000);
    step("adds_x",  0, 0, 2'b00, 6'b001001, 4'b1110, 4'b0100, 4'd6, 12'b0000_0000_0000, 4'b0000);
    step("adds_wb", 0, 0, 2'b00, 6'b001001, 4'b1110, 4'b0100, 4'd8, 12'b0001_0000_0000, 4'b0100);

    // CMP with Z=1 then BEQ (taken, BL bit set)
    step("cmp1_f",  0, 1, 2'b00, 6'b010101, 4'b1110, 4'b0110, 4'd0, C_F1, 4'b0100);
    step("cmp1_d",  0, 0, 2'b00, 6'b010101, 4'b1110, 4'b0110, 4'd1, C_DEC, 4'b0100);
    step("cmp1_x",  0, 0, 2'b00, 6'b010101, 4'b1110, 4'b0110, 4'd6, 12'b0000_0000_0001, 4'b0100);
    step("cmp1_wb", 0, 0, 2'b00, 6'b010101, 4'b1110, 4'b0000, 4'd8, 12'b0000_0000_0001, 4'b0110);
    step("beq1_f",  0, 1, 2'b10, 6'b010000, 4'b0000, 4'b0000, 4'd0, C_F1, 4'b0110);
    step("beq1_d",  0, 0, 2'b10, 6'b010000, 4'b0000, 4'b0000, 4'd1, C_DEC, 4'b0110);
    step("beq1_b",  0, 0, 2'b10, 6'b010000, 4'b0000, 4'b0000, 4'd9, C_BR, 4'b0110);

    // CMP with Z=0 then BEQ (not taken)
    step("cmp2_f",  0, 1, 2'b00, 6'b010101, 4'b1110, 4'b1000, 4'd0, C_F1, 4'b0110);
    step("cmp2_d",  0, 0, 2'b00, 6'b010101, 4'b1110, 4'b1000, 4'd1, C_DEC, 4'b0110);
    step("cmp2_x",  0, 0, 2'b00, 6'b010101, 4'b1110, 4'b1000, 4'd6, 12'b0000_0000_0001, 4'b0110);
    step("cmp2_wb", 0, 0, 2'b00, 6'b010101, 4'b1110, 4'b0100, 4'd8, 12'b0000_0000_0001, 4'b1000);
    step("beq2_f",  0, 1, 2'b10, 6'b000000, 4'b0000, 4'b0100, 4'd0, C_F1, 4'b1000);
    step("beq2_d",  0, 0, 2'b10, 6'b000000, 4'b0000, 4'b0100, 4'd1, C_DEC, 4'b1000);

    // LDR: one fetch stall, ignored mem_ready in DECODE/MEMADR, 3 MEMRD stalls
    step("ldr_fs",  0, 0, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd0, C_F0, 4'b1000);
    step("ldr_f",   0, 1, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd0, C_F1, 4'b1000);
    step("ldr_d",   0, 1, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd1, C_DEC, 4'b1000);
    step("ldr_a",   0, 1, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd2, C_MADR, 4'b1000);
    step("ldr_r0",  0, 0, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd3, C_MRD, 4'b1000);
    step("ldr_r1",  0, 0, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd3, C_MRD, 4'b1000);
    step("ldr_r2",  0, 0, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd3, C_MRD, 4'b1000);
    step("ldr_r3",  0, 1, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd3, C_MRD, 4'b1000);
    step("ldr_wb",  0, 1, 2'b01, 6'b011001, 4'b1110, 4'b0000, 4'd4, C_MWB, 4'b1000);

    // STR with 2 wait cycles
    step("str_f",   0, 1, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd0, C_F1, 4'b1000);
    step("str_d",   0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd1, C_DEC, 4'b1000);
    step("str_a",   0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd2, C_MADR, 4'b1000);
    step("str_w0",  0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd5, C_MWR, 4'b1000);
    step("str_w1",  0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd5, C_MWR, 4'b1000);
    step("str_w2",  0, 1, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd5, C_MWR, 4'b1000);

    // STR interrupted by reset mid-wait
    step("strr_f",  0, 1, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd0, C_F1, 4'b1000);
    step("strr_d",  0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd1, C_DEC, 4'b1000);
    step("strr_a",  0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd2, C_MADR, 4'b1000);
    step("strr_w0", 0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd5, C_MWR, 4'b1000);
    step("strr_w1", 1, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd5, C_MWR, 4'b1000);
    step("strr_rs", 0, 0, 2'b01, 6'b011000, 4'b1110, 4'b0000, 4'd0, C_F0, 4'b0000);

    // op=11 NOP and cond=NV
    step("nop_f",   0, 1, 2'b11, 6'b001001, 4'b1110, 4'b1111, 4'd0, C_F1, 4'b0000);
    step("nop_d",   0, 0, 2'b11, 6'b001001, 4'b1110, 4'b1111, 4'd1, C_DEC, 4'b0000);
    step("nv_f",    0, 1, 2'b00, 6'b001001, 4'b1111, 4'b1111, 4'd0, C_F1, 4'b0000);
    step("nv_d",    0, 0, 2'b00, 6'b001001, 4'b1111, 4'b1111, 4'd1, C_DEC, 4'b0000);

    // ORR immediate without S: no flag load
    step("orr_f",   0, 1, 2'b00, 6'b111000, 4'b1110, 4'b1111, 4'd0, C_F1, 4'b0000);
    step("orr_d",   0, 0, 2'b00, 6'b111000, 4'b1110, 4'b1111, 4'd1, C_DEC, 4'b0000);
    step("orr_x",   0, 0, 2'b00, 6'b111000, 4'b1110, 4'b1111, 4'd7, 12'b0000_0001_0011, 4'b0000);
    step("orr_wb",  0, 0, 2'b00, 6'b111000, 4'b1110, 4'b1111, 4'd8, 12'b0001_0000_0011, 4'b0000);

    // SUBS immediate: flags <- 0011
    step("subs_f",  0, 1, 2'b00, 6'b100101, 4'b1110, 4'b0011, 4'd0, C_F1, 4'b0000);
    step("subs_d",  0, 0, 2'b00, 6'b100101, 4'b1110, 4'b0011, 4'd1, C_DEC, 4'b0000);
    step("subs_x",  0, 0, 2'b00, 6'b100101, 4'b1110, 4'b0011, 4'd7, 12'b0000_0001_0001, 4'b0000);
    step("subs_wb", 0, 0, 2'b00, 6'b100101, 4'b1110, 4'b1100, 4'd8, 12'b0001_0000_0001, 4'b0011);

    // N=0,V=1: BGE not taken, BLT taken
    step("bge_f",   0, 1, 2'b10, 6'b000000, 4'b1010, 4'b0000, 4'd0, C_F1, 4'b0011);
    step("bge_d",   0, 0, 2'b10, 6'b000000, 4'b1010, 4'b0000, 4'd1, C_DEC, 4'b0011);
    step("blt_f",   0, 1, 2'b10, 6'b000000, 4'b1011, 4'b0000, 4'd0, C_F1, 4'b0011);
    step("blt_d",   0, 0, 2'b10, 6'b000000, 4'b1011, 4'b0000, 4'd1, C_DEC, 4'b0011);
    step("blt_b",   0, 0, 2'b10, 6'b000000, 4'b1011, 4'b0000, 4'd9, C_BR, 4'b0011);
    step("end_f",   0, 0, 2'b00, 6'b000000, 4'b1110, 4'b0000, 4'd0, C_F0, 4'b0011);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
